// File: rtl/bcd_adder_scan_display.sv
// Registered adder whose sum is converted to decimal (iterative double-dabble) or hex
// digits and time-multiplexed onto an active-low 7-segment display.
module bcd_adder_scan_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              load,
  input  logic              hex_mode,
  output logic              busy,
  output logic [WIDTH:0]    sum,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  function automatic int dec_digits(input int bits);
    longint unsigned v;
    int n;
    v = (64'd1 << bits) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        n++;
      end
    end
    return (n < 1) ? 1 : n;
  endfunction

  localparam int SUM_W = WIDTH + 1;
  localparam int NDEC  = dec_digits(SUM_W);
  localparam int NHEX  = (SUM_W + 3) / 4;
  localparam int NCONV = (NDEC > NHEX) ? NDEC : NHEX;
  // Digit store covers both every converted digit and every display position.
  localparam int NS    = (NCONV > DIGITS) ? NCONV : DIGITS;
  localparam int SW    = 4 * NS;
  localparam int CNT_W = $clog2(SUM_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {IDLE, CONV} state_t;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] v, input logic in_bit);
    logic [SW-1:0] r;
    r = v;
    for (int i = 0; i < NS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return {r[SW-2:0], in_bit};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  state_t             state;
  logic               conv_hex;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SUM_W-1:0]   bin_sr;
  logic [SW-1:0]      bcd_sr;
  logic [SW-1:0]      bcd_next;
  logic [SW-1:0]      shown;
  logic               shown_hex;
  logic [SUM_W-1:0]   sum_next;
  logic [IDX_W-1:0]   idx;
  logic [DIV_W-1:0]   div_cnt;

  assign sum_next = SUM_W'(a) + SUM_W'(b);
  assign bcd_next = dabble(bcd_sr, bin_sr[SUM_W-1]);

  // Control FSM: capture, convert, then publish the digits in one step as busy falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sum       <= '0;
      conv_hex  <= 1'b0;
      bit_cnt   <= '0;
      shown     <= '0;
      shown_hex <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sum      <= sum_next;
            conv_hex <= hex_mode;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          if (conv_hex) begin
            shown     <= SW'(sum);
            shown_hex <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WIDTH)) begin
              shown     <= bcd_next;
              shown_hex <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conversion shift registers are pure data and are re-initialised on every load.
  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      bin_sr <= sum_next;
      bcd_sr <= '0;
    end else if (state == CONV) begin
      bin_sr <= bin_sr << 1;
      bcd_sr <= bcd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Stage p0: select and decode the digit for the active position.
  logic              overflow_p0;
  logic              upper_nz_p0;
  logic [3:0]        digit_p0;
  logic [6:0]        seg_p0;
  logic [DIGITS-1:0] an_p0;
  logic              dp_p0;

  always_comb begin
    overflow_p0 = 1'b0;
    upper_nz_p0 = 1'b0;
    for (int i = DIGITS; i < NS; i++) begin
      if (shown[4*i +: 4] != 4'd0) overflow_p0 = 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      if (i >= int'(idx) && shown[4*i +: 4] != 4'd0) upper_nz_p0 = 1'b1;
    end
    digit_p0 = shown[4*int'(idx) +: 4];
    if (overflow_p0)                     seg_p0 = SEG_DASH;
    else if (idx != '0 && !upper_nz_p0)  seg_p0 = SEG_BLANK;
    else                                 seg_p0 = encode(digit_p0);
    an_p0 = ~(DIGITS'(1) << idx);
    dp_p0 = ~(idx == '0 && shown_hex);
  end

  // Stage p1: anode, segment and dp registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= ~DIGITS'(1);
      seg <= 7'b0000001;
      dp  <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_bcd_adder_scan_display.sv
// Bench for bcd_adder_scan_display: two instances (4 and 2 digits) share stimulus and are
// compared against an arithmetic model of what the display should read.
module tb_bcd_adder_scan_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       load = 1'b0;
  logic       hex_mode = 1'b0;

  logic       busy_a, busy_b;
  logic [8:0] sum_a, sum_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a;
  logic [1:0] an_b;
  logic       dp_a, dp_b;

  int     checks = 0;
  int     errors = 0;
  longint shown_val = 0;
  bit     shown_hex = 1'b0;

  always #5 clk = ~clk;

  bcd_adder_scan_display #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(op_a), .b(op_b), .load(load), .hex_mode(hex_mode),
    .busy(busy_a), .sum(sum_a), .seg(seg_a), .an(an_a), .dp(dp_a)
  );

  bcd_adder_scan_display #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(op_a), .b(op_b), .load(load), .hex_mode(hex_mode),
    .busy(busy_b), .sum(sum_b), .seg(seg_b), .an(an_b), .dp(dp_b)
  );

  function automatic logic [6:0] enc(input longint d);
    case (d)
      0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
      9: return 7'b0000100;  10: return 7'b0001000;  11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010;  14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic longint ipow(input longint base, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * base;
    return r;
  endfunction

  // What a display of 'digits' positions shows at position 'pos' for value/mode.
  function automatic logic [6:0] exp_seg(input longint val, input bit hx, input int digits,
                                         input int pos);
    longint base;
    longint p;
    base = hx ? 16 : 10;
    if (val > ipow(base, digits) - 1) return 7'b1111110;
    p = ipow(base, pos);
    if (pos > 0 && val < p) return 7'b1111111;
    return enc((val / p) % base);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag, input int digits, input logic [3:0] an_v,
                            input logic [6:0] seg_v, input logic dp_v);
    int pos;
    logic [3:0] mask;
    pos = 0;
    mask = 4'((1 << digits) - 1);
    for (int i = 0; i < digits; i++) if (an_v[i] == 1'b0) pos = i;
    chk({tag, "_an"}, 32'(an_v & mask), 32'(~(4'd1 << pos) & mask));
    chk({tag, "_seg"}, 32'(seg_v), 32'(exp_seg(shown_val, shown_hex, digits, pos)));
    chk({tag, "_dp"}, 32'(dp_v), 32'((pos == 0 && shown_hex) ? 1'b0 : 1'b1));
  endtask

  task automatic check_both(input string tag);
    check_disp({tag, "_d4"}, 4, an_a, seg_a, dp_a);
    check_disp({tag, "_d2"}, 2, {2'b00, an_b}, seg_b, dp_b);
  endtask

  task automatic settle_and_show(input string tag, input int cycles);
    tick();
    tick();
    for (int i = 0; i < cycles; i++) begin
      check_both(tag);
      tick();
    end
  endtask

  task automatic run_conv(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input bit hx, input bit poke);
    int n;
    op_a = x;
    op_b = y;
    hex_mode = hx;
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 50) begin
      check_both({tag, "_old"});
      if (poke && n == 2) begin
        op_a = ~x;
        op_b = 8'd1;
        hex_mode = ~hx;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      n++;
      tick();
    end
    load = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), hx ? 32'd1 : 32'd9);
    chk({tag, "_busy2"}, 32'(busy_b), 32'd0);
    chk({tag, "_sum4"}, 32'(sum_a), 32'(x) + 32'(y));
    chk({tag, "_sum2"}, 32'(sum_b), 32'(x) + 32'(y));
    shown_val = longint'(x) + longint'(y);
    shown_hex = hx;
    settle_and_show(tag, 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an4"}, 32'(an_a), 32'b1110);
    chk({tag, "_an2"}, 32'(an_b), 32'b10);
    chk({tag, "_seg"}, 32'(seg_a), 32'b0000001);
    chk({tag, "_dp"}, 32'(dp_a), 32'd1);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_sum"}, 32'(sum_a), 32'd0);
  endtask

  initial begin
    logic [3:0] prev_an;
    int run;
    bit first;

    // Asynchronous reset from power-up.
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("rst0");
    tick();
    tick();
    #2 rst_n = 1'b1;
    shown_val = 0;
    shown_hex = 1'b0;
    settle_and_show("zero", 8);

    // Scan: each anode held SCAN_DIV=4 cycles, stepping one position left.
    prev_an = an_a;
    run = 1;
    first = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (an_a === prev_an) begin
        run++;
      end else begin
        if (!first) chk("scan_hold", 32'(run), 32'd4);
        chk("scan_step", 32'(an_a), 32'({prev_an[2:0], prev_an[3]}));
        first = 1'b0;
        prev_an = an_a;
        run = 1;
      end
    end

    run_conv("dec255", 8'd200, 8'd55, 1'b0, 1'b0);
    run_conv("hex1fe", 8'd255, 8'd255, 1'b1, 1'b0);
    run_conv("dec110", 8'd60, 8'd50, 1'b0, 1'b0);
    run_conv("ignore", 8'd10, 8'd20, 1'b0, 1'b1);

    // Reset arriving mid-conversion aborts it.
    op_a = 8'd123;
    op_b = 8'd45;
    hex_mode = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    #2 rst_n = 1'b1;
    shown_val = 0;
    shown_hex = 1'b0;
    settle_and_show("after_rst", 6);

    for (int k = 0; k < 10; k++) begin
      run_conv("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    run_conv("hex0", 8'd0, 8'd0, 1'b1, 1'b0);
    run_conv("dec9", 8'd4, 8'd5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
